pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_pkg.sv | 10 +
 rtl/pc_ras.sv | 39 +++
 rtl/pc_unit.sv | 91 +++++++++
 tb/tb_pc_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: FSM state type and default parameter values shared by the PC unit.
package pc_unit_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;
  localparam int ADDR_W_DEF      = 8;
  localparam int IMM_W_DEF       = 8;
  localparam int INSTR_BYTES_DEF = 4;
  localparam int ISSUE_W_DEF     = 2;
  localparam int RAS_DEPTH_DEF   = 4;
  localparam int RESET_VEC_DEF   = 0;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address stack as a circular buffer plus occupancy count.
// Ports: clk, rst_n (async active-low), push/pop strobes, din (address to push),
// full/empty status, top (most recently pushed entry).
// A push while full overwrites the oldest entry; a pop while empty does nothing.
module pc_ras #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   cnt;
  assign full  = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign top   = mem[ptr - PW'(1)];
  // ptr is the next write slot; wrapping it makes a push while full overwrite the oldest entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      cnt <= full ? cnt : cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - (PW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push) mem[ptr] <= din;
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with BOOT/RUN/HALTED control, branches and optional return-address stack.
// Ports: clk, rst_n (async active-low); controls stall, rollback, branch1, branch2,
// call, ret, immdata (signed offset in instructions), halt, resume;
// outputs pc_out, pc_valid, ras_full, ras_empty, ras_ovf, ras_unf (all registered).
// Macro PC_UNIT_RAS_EN builds in the return-address stack; without it call acts as
// branch1, ret acts as sequential and the RAS status outputs are tied off.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int IMM_W       = IMM_W_DEF,
  parameter int INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int ISSUE_W     = ISSUE_W_DEF,
  parameter int RAS_DEPTH   = RAS_DEPTH_DEF,
  parameter int RESET_VEC   = RESET_VEC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              rollback,
  input  logic              branch1,
  input  logic              branch2,
  input  logic              call,
  input  logic              ret,
  input  logic [IMM_W-1:0]  immdata,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_out,
  output logic              pc_valid,
  output logic              ras_full,
  output logic              ras_empty,
  output logic              ras_ovf,
  output logic              ras_unf
);
  localparam logic [ADDR_W-1:0] IB  = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] SEQ = ADDR_W'(ISSUE_W * INSTR_BYTES);
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif
  state_t            state, state_n;
  logic [ADDR_W-1:0] off, seq_pc, pc_n, top;
  logic              adv, do_call, do_ret, push, pop, full, empty, ovf_n, unf_n;
  // offset is sign-extended to PC width first, so the product wraps modulo 2^ADDR_W
  assign off     = ADDR_W'($signed(immdata)) * IB;
  assign seq_pc  = pc_out + SEQ;
  assign adv     = state == RUN && !stall && !halt;
  assign do_call = adv && !rollback && !branch1 && !branch2 && call;
  assign do_ret  = adv && !rollback && !branch1 && !branch2 && !call && ret;
  assign push    = do_call && RAS_ON;
  assign pop     = do_ret && !empty;
  assign ovf_n   = push && full;
  assign unf_n   = do_ret && empty && RAS_ON;
`ifdef PC_UNIT_RAS_EN
  pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(seq_pc),
    .full(full), .empty(empty), .top(top)
  );
`else
  assign full  = 1'b0;
  assign empty = 1'b1;
  assign top   = '0;
`endif
  assign ras_full  = full;
  assign ras_empty = empty;
  always_comb begin
    state_n = state;
    if (state == BOOT) state_n = RUN;
    else if (!stall && state == RUN && halt) state_n = HALTED;
    else if (!stall && state == HALTED && resume && !halt) state_n = RUN;
    pc_n = rollback ? pc_out + IB :
           (branch1 || (!branch2 && call)) ? pc_out + off :
           branch2 ? pc_out + off + IB :
           pop ? top : seq_pc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= BOOT;
      pc_out   <= ADDR_W'(RESET_VEC);
      pc_valid <= 1'b0;
      ras_ovf  <= 1'b0;
      ras_unf  <= 1'b0;
    end else begin
      state    <= state_n;
      pc_valid <= state_n == RUN;
      ras_ovf  <= ovf_n;
      ras_unf  <= unf_n;
      if (adv) pc_out <= pc_n;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a behavioural model.
module tb_pc_unit;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  logic clk = 0, rst_n = 0, stall = 0, rollback = 0, branch1 = 0, branch2 = 0;
  logic call = 0, ret = 0, halt = 0, resume = 0;
  logic [7:0] immdata = 0;
  logic [7:0] pc_out;
  logic pc_valid, ras_full, ras_empty, ras_ovf, ras_unf;
  int n_cmp = 0, n_bad = 0;
  int m_pc, m_mode;
  int m_stk[$];
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .rollback(rollback), .branch1(branch1),
    .branch2(branch2), .call(call), .ret(ret), .immdata(immdata), .halt(halt),
    .resume(resume), .pc_out(pc_out), .pc_valid(pc_valid), .ras_full(ras_full),
    .ras_empty(ras_empty), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(pc_out), m_pc);
    chk({tag, ".valid"}, 32'(pc_valid), 32'(m_mode == 1));
    chk({tag, ".full"}, 32'(ras_full), 32'(m_stk.size() == 4));
    chk({tag, ".empty"}, 32'(ras_empty), 32'(m_stk.size() == 0));
    chk({tag, ".ovf"}, 32'(ras_ovf), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(ras_unf), 32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = 0; m_mode = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic clear();
    stall = 0; rollback = 0; branch1 = 0; branch2 = 0; call = 0; ret = 0;
    halt = 0; resume = 0; immdata = 0;
  endtask

  // mode: 0 = booting, 1 = running, 2 = halted
  task automatic step(input string tag);
    int imm = int'($signed(immdata));
    bit ovf = 0, unf = 0;
    if (m_mode == 0) m_mode = 1;
    else if (stall) begin end
    else if (m_mode == 2) begin
      if (resume && !halt) m_mode = 1;
    end else if (halt) m_mode = 2;
    else if (rollback) m_pc += 4;
    else if (branch1) m_pc += imm * 4;
    else if (branch2) m_pc += imm * 4 + 4;
    else if (call) begin
      if (RAS) begin
        if (m_stk.size() == 4) begin void'(m_stk.pop_front()); ovf = 1; end
        m_stk.push_back((m_pc + 8) & 255);
      end
      m_pc += imm * 4;
    end else if (ret && RAS && m_stk.size() > 0) m_pc = m_stk.pop_back();
    else begin
      if (ret && RAS) unf = 1;
      m_pc += 8;
    end
    m_pc &= 255; m_ovf = ovf; m_unf = unf;
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
    step("boot");
    chk("boot_valid", 32'(pc_valid), 1);
    chk("boot_pc", 32'(pc_out), 0);
    step("seq1"); chk("seq1_lit", 32'(pc_out), 8);
    step("seq2"); chk("seq2_lit", 32'(pc_out), 16);
    step("seq3"); chk("seq3_lit", 32'(pc_out), 24);
    branch1 = 1; immdata = 8'hFE; step("to10");
    rollback = 1; immdata = 3; step("rb_b1"); chk("rb_b1_lit", 32'(pc_out), 'h14);
    rollback = 0; immdata = 8'hFF; step("back10");
    immdata = 8'hFE; step("b1_neg"); chk("b1_neg_lit", 32'(pc_out), 'h08);
    immdata = 2; step("back10b");
    branch1 = 0; branch2 = 1; immdata = 1; step("b2"); chk("b2_lit", 32'(pc_out), 'h18);
    branch2 = 0; branch1 = 1; immdata = 56; step("toF8"); chk("toF8_lit", 32'(pc_out), 'hF8);
    clear(); step("wrap_seq"); chk("wrap_seq_lit", 32'(pc_out), 'h00);
    rollback = 1; step("to04");
    rollback = 0; branch1 = 1; immdata = 127; step("wrap_b1"); chk("wrap_b1_lit", 32'(pc_out), 'h00);
    clear(); call = 1; immdata = 8;
    for (int i = 0; i < 5; i++) step($sformatf("call%0d", i));
`ifdef PC_UNIT_RAS_EN
    chk("call5_ovf", 32'(ras_ovf), 1);
    chk("call5_full", 32'(ras_full), 1);
`endif
    call = 0; ret = 1;
    for (int i = 0; i < 5; i++) begin
      step($sformatf("ret%0d", i));
`ifdef PC_UNIT_RAS_EN
      chk($sformatf("ret%0d_lit", i), 32'(pc_out), i == 4 ? 'h30 : 'h88 - 32 * i);
`endif
    end
`ifdef PC_UNIT_RAS_EN
    chk("ret5_unf", 32'(ras_unf), 1);
`endif
    clear(); stall = 1; branch1 = 1; immdata = 5;
    for (int i = 0; i < 3; i++) step($sformatf("stall%0d", i));
    clear(); halt = 1; rollback = 1; step("halt");
    chk("halt_valid", 32'(pc_valid), 0);
    clear(); branch1 = 1; immdata = 9; step("halted_b1");
    clear(); halt = 1; resume = 1; step("halt_over_resume");
    halt = 0; step("resume");
    chk("resume_valid", 32'(pc_valid), 1);
    clear(); step("resume_adv");
    async_reset("rst_pre");
    clear(); step("boot2");
    call = 1; immdata = 4;
    step("push1"); step("push2");
    clear();
    async_reset("rst_mid");
    chk("rst_mid_empty", 32'(ras_empty), 1);
    chk("rst_mid_pc", 32'(pc_out), 0);
    step("boot3");
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        clear();
        async_reset("rnd_rst");
      end
      stall = $urandom_range(0, 7) == 0;
      rollback = $urandom_range(0, 7) == 0;
      branch1 = $urandom_range(0, 5) == 0;
      branch2 = $urandom_range(0, 5) == 0;
      call = $urandom_range(0, 3) == 0;
      ret = $urandom_range(0, 2) == 0;
      halt = $urandom_range(0, 19) == 0;
      resume = $urandom_range(0, 2) == 0;
      immdata = 8'($urandom);
      step("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
